// File: rtl/dual_port_bram_pkg.sv
// dual_port_bram_pkg: default geometry and saturating counter helper for dual_port_bram.
package dual_port_bram_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 1024;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [1:0] n);
        logic [32:0] s;
        s = {1'b0, v} + {31'b0, n};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/dual_port_bram_port_ctrl.sv
// bram_port_ctrl: per-port range check, access classification and registered read data.
module bram_port_ctrl
    import dual_port_bram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  rd_o,
    output logic                  wr_o,
    output logic                  wr_en_o,
    output logic                  oob_o,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  in_range;
    logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

    always_comb begin
        in_range  = {1'b0, addr_i} < LIMIT;
        rd_o      = ce_i & ~we_i;
        wr_o      = ce_i & we_i;
        wr_en_o   = wr_o & in_range;
        oob_o     = ce_i & ~in_range;
        idx_o     = addr_i[IDX_W-1:0];
        rd_data_d = rd_o ? (in_range ? mem_rdata_i : '0) : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data_q <= '0;
        else      rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dual_port_bram.sv
// dual_port_bram: read-first dual-port RAM with sticky error flags and saturating access counters.
// Define BRAM_COLLISION_CHECK_EN to detect same-address dual writes on err_collision.
module dual_port_bram
    import dual_port_bram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] address0,
    input  logic [DATA_WIDTH-1:0] wr_data0,
    output logic [DATA_WIDTH-1:0] rd_data0,
    input  logic                  ce1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] address1,
    input  logic [DATA_WIDTH-1:0] wr_data1,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic                  err_oob,
    output logic                  err_collision,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);

    localparam int IW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]         idx0, idx1;
    logic                  rd0, rd1, wr0, wr1, wen0, wen1, oob0, oob1;
    logic                  err_oob_d, err_oob_q;
    logic [31:0]           rd_count_d, rd_count_q, wr_count_d, wr_count_q;

    bram_port_ctrl #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_port0 (
        .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we0), .addr_i(address0),
        .mem_rdata_i(mem[idx0]), .idx_o(idx0), .rd_o(rd0), .wr_o(wr0),
        .wr_en_o(wen0), .oob_o(oob0), .rd_data_o(rd_data0)
    );

    bram_port_ctrl #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_port1 (
        .clk(clk), .rst(rst), .ce_i(ce1), .we_i(we1), .addr_i(address1),
        .mem_rdata_i(mem[idx1]), .idx_o(idx1), .rd_o(rd1), .wr_o(wr1),
        .wr_en_o(wen1), .oob_o(oob1), .rd_data_o(rd_data1)
    );

    // Port 1 is applied last so it wins a same-address dual write.
    always_ff @(posedge clk) begin
        if (wen0) mem[idx0] <= wr_data0;
        if (wen1) mem[idx1] <= wr_data1;
    end

    always_comb begin
        err_oob_d  = err_oob_q | oob0 | oob1;
        rd_count_d = sat_inc(rd_count_q, {1'b0, rd0} + {1'b0, rd1});
        wr_count_d = sat_inc(wr_count_q, {1'b0, wr0} + {1'b0, wr1});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_oob_q  <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            err_oob_q  <= err_oob_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

`ifdef BRAM_COLLISION_CHECK_EN
    logic err_col_d, err_col_q;

    always_comb err_col_d = err_col_q | (wen0 & wen1 & (idx0 == idx1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_col_q <= 1'b0;
        else      err_col_q <= err_col_d;
    end

    assign err_collision = err_col_q;
`else
    assign err_collision = 1'b0;
`endif

    assign err_oob  = err_oob_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_dual_port_bram.sv
// tb_dual_port_bram: directed scoreboard bench for dual_port_bram.
module tb_dual_port_bram;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ce0, we0, ce1, we1;
    logic [31:0] address0, address1, wr_data0, wr_data1;
    logic [31:0] rd_data0, rd_data1, rd_count, wr_count;
    logic        err_oob, err_collision;

    exp_t        sb[$];
    logic [31:0] model [1024];
    logic [31:0] e_rd, e_wr, e_rd0, e_rd1;
    logic        e_oob, e_col;
    int          checks, errors;

    dual_port_bram dut (
        .clk(clk), .rst(rst),
        .ce0(ce0), .we0(we0), .address0(address0), .wr_data0(wr_data0), .rd_data0(rd_data0),
        .ce1(ce1), .we1(we1), .address1(address1), .wr_data1(wr_data1), .rd_data1(rd_data1),
        .err_oob(err_oob), .err_collision(err_collision),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat_add(input logic [31:0] v, input int n);
        longint t;
        t = longint'(v) + longint'(n);
        return (t > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
    endfunction

    task automatic check_status(input string tag);
        chk({tag, "_rd0"}, rd_data0, e_rd0);
        chk({tag, "_rd1"}, rd_data1, e_rd1);
        chk({tag, "_rdcnt"}, rd_count, e_rd);
        chk({tag, "_wrcnt"}, wr_count, e_wr);
        chk({tag, "_oob"}, {31'b0, err_oob}, {31'b0, e_oob});
        chk({tag, "_col"}, {31'b0, err_collision}, {31'b0, e_col});
    endtask

    task automatic step(input string tag,
                        input logic c0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic c1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        int nr, nw;
        @(negedge clk);
        ce0 = c0; we0 = w0; address0 = a0; wr_data0 = d0;
        ce1 = c1; we1 = w1; address1 = a1; wr_data1 = d1;
        nr = 0;
        nw = 0;
        if (c0 && !w0) begin
            sb.push_back('{{tag, "_p0"}, 0, (a0 < 1024) ? model[a0[9:0]] : 32'h0});
            nr++;
        end
        if (c1 && !w1) begin
            sb.push_back('{{tag, "_p1"}, 1, (a1 < 1024) ? model[a1[9:0]] : 32'h0});
            nr++;
        end
        if (c0 && w0) nw++;
        if (c1 && w1) nw++;
        if ((c0 && a0 >= 1024) || (c1 && a1 >= 1024)) e_oob = 1'b1;
`ifdef BRAM_COLLISION_CHECK_EN
        if (c0 && w0 && c1 && w1 && a0 == a1 && a0 < 1024) e_col = 1'b1;
`endif
        if (c0 && w0 && a0 < 1024) model[a0[9:0]] = d0;
        if (c1 && w1 && a1 < 1024) model[a1[9:0]] = d1;
        e_rd = sat_add(e_rd, nr);
        e_wr = sat_add(e_wr, nw);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.port == 0) e_rd0 = e.val;
            else e_rd1 = e.val;
            chk(e.tag, (e.port == 0) ? rd_data0 : rd_data1, e.val);
        end
        check_status(tag);
        ce0 = 1'b0;
        ce1 = 1'b0;
    endtask

    task automatic clear_model_regs();
        e_rd = '0; e_wr = '0; e_rd0 = '0; e_rd1 = '0; e_oob = 1'b0; e_col = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) model[i] = '0;
        clear_model_regs();
        rst = 1'b0;
        ce0 = 1'b0; we0 = 1'b0; address0 = '0; wr_data0 = '0;
        ce1 = 1'b0; we1 = 1'b0; address1 = '0; wr_data1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_status("reset");
        @(negedge clk);
        rst = 1'b1;

        step("w5",  1, 1, 5, 32'hDEAD_BEEF,  0, 0, 0, 0);
        step("r5",  0, 0, 0, 0,              1, 0, 5, 0);
        step("w7",  0, 0, 0, 0,              1, 1, 7, 32'h22);
        step("rf7", 1, 1, 7, 32'h11,         1, 0, 7, 0);
        step("r7",  1, 0, 7, 0,              0, 0, 0, 0);
        step("idle", 0, 0, 0, 0,             0, 0, 0, 0);
        step("ww3", 1, 1, 3, 32'hAA,         1, 1, 3, 32'hBB);
        step("r3",  1, 0, 3, 0,              1, 0, 3, 0);
        step("w0",  1, 1, 0, 32'h55,         1, 1, 9, 32'h99);
        step("rob", 1, 0, 1024, 0,           1, 0, 9, 0);
        step("wob", 1, 1, 1024, 32'h77,      1, 1, 32'hFFFF_FFFF, 32'h66);
        step("r0",  1, 0, 0, 0,              1, 0, 1023, 0);

        // Reset mid-burst: outputs clear asynchronously while memory survives.
        @(negedge clk);
        ce0 = 1'b1; we0 = 1'b0; address0 = 5;
        ce1 = 1'b1; we1 = 1'b0; address1 = 7;
        @(posedge clk);
        #2;
        rst = 1'b0;
        clear_model_regs();
        #1;
        check_status("rst_async");
        @(posedge clk);
        #1;
        check_status("rst_hold");
        @(negedge clk);
        ce0 = 1'b0;
        ce1 = 1'b0;
        rst = 1'b1;
        step("rr", 1, 0, 5, 0,               1, 0, 3, 0);

        // Counter saturation.
        @(negedge clk);
        force dut.rd_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.rd_count_q;
        e_rd = 32'hFFFF_FFFE;
        step("sat1", 1, 0, 7, 0,             1, 0, 0, 0);
        step("sat2", 1, 0, 3, 0,             1, 0, 5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
